// File: rtl/btn_intr_pkg.sv
// Shared types and default timing constants for the button interrupt arbiter.
package btn_intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_ASSERT = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  localparam logic [7:0] ACK_TIMEOUT_DEF = 8'hFF;
  localparam logic [7:0] GAP_CLKS_DEF    = 8'h03;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: lowest set request index at or after last+1, wrapping.
module rr_priority_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  logic [W-1:0] cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = W'((32'(last_i) + k) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/btn_intr_arbiter.sv
// Latches one-shot button presses and raises one CPU interrupt at a time,
// granting pending buttons round-robin with ack timeout and inter-interrupt gap.
module btn_intr_arbiter
  import btn_intr_pkg::*;
#(
  parameter int unsigned N_BTN       = 4,
  parameter logic [7:0]  ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter logic [7:0]  GAP_CLKS    = GAP_CLKS_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_BTN-1:0]         BTN_PULSE,
  input  logic                     INTR_ACK,
  input  logic                     CLR_OVR,
  output logic                     INTR,
  output logic [$clog2(N_BTN)-1:0] INTR_ID,
  output logic [N_BTN-1:0]         PENDING,
  output logic [N_BTN-1:0]         OVERRUN,
  output logic                     TIMEOUT
);

  localparam int unsigned    IDW      = $clog2(N_BTN);
  localparam logic [IDW-1:0] LAST_RST = IDW'(N_BTN - 1);

  state_t           state_q;
  logic [7:0]       cnt_q;
  logic             intr_q;
  logic             timeout_q;
  logic [IDW-1:0]   intr_id_q;
  logic [IDW-1:0]   last_q;
  logic [N_BTN-1:0] btn_q;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] ovr_q, ovr_d;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] grant_clr;
  logic [IDW-1:0]   pick_idx;
  logic             pick_valid;
  logic             gap_done;

  rr_priority_pick #(.N(N_BTN), .W(IDW)) u_pick (
    .req_i   (pend_q),
    .last_i  (last_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign rise     = BTN_PULSE & ~btn_q;
  // 9-bit compare so GAP_CLKS=0 still spends exactly one cycle in the gap
  assign gap_done = (9'(cnt_q) + 9'd1) >= 9'(GAP_CLKS);

  always_comb begin
    grant_clr = '0;
    if (state_q == ST_ARB && pick_valid) grant_clr[pick_idx] = 1'b1;
    // A press landing in the grant cycle re-arms the bit instead of counting as overrun
    pend_d = (pend_q & ~grant_clr) | rise;
    ovr_d  = (CLR_OVR ? '0 : ovr_q) | (rise & pend_q & ~grant_clr);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_q  <= '0;
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      btn_q  <= BTN_PULSE;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      intr_q    <= 1'b0;
      timeout_q <= 1'b0;
      intr_id_q <= '0;
      last_q    <= LAST_RST;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (|pend_q) state_q <= ST_ARB;
        end
        ST_ARB: begin
          cnt_q <= '0;
          if (pick_valid) begin
            intr_id_q <= pick_idx;
            last_q    <= pick_idx;
            intr_q    <= 1'b1;
            state_q   <= ST_ASSERT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ASSERT: begin
          if (INTR_ACK) begin
            intr_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_GAP;
          end else if (cnt_q == ACK_TIMEOUT) begin
            timeout_q <= 1'b1;
            intr_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_GAP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          cnt_q   <= '0;
          intr_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign INTR    = intr_q;
  assign INTR_ID = intr_id_q;
  assign PENDING = pend_q;
  assign OVERRUN = ovr_q;
  assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_btn_intr_arbiter.sv
// Self-checking bench for btn_intr_arbiter: vector table, directed corner sequences, random vs. model.
module tb_btn_intr_arbiter;

  localparam int N      = 4;
  localparam int ACK_TO = 255;
  localparam int GAP    = 3;

  logic       CLK;
  logic       RST;
  logic [3:0] BTN_PULSE;
  logic       INTR_ACK;
  logic       CLR_OVR;
  logic       INTR;
  logic [1:0] INTR_ID;
  logic [3:0] PENDING;
  logic [3:0] OVERRUN;
  logic       TIMEOUT;

  btn_intr_arbiter #(.N_BTN(4), .ACK_TIMEOUT(8'hFF), .GAP_CLKS(8'h03)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BTN_PULSE (BTN_PULSE),
    .INTR_ACK  (INTR_ACK),
    .CLR_OVR   (CLR_OVR),
    .INTR      (INTR),
    .INTR_ID   (INTR_ID),
    .PENDING   (PENDING),
    .OVERRUN   (OVERRUN),
    .TIMEOUT   (TIMEOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks;
  int failures;

  // Behavioural model: pending/overrun bit arrays plus counters for assert age and gap length.
  bit m_pend[N];
  bit m_ovr[N];
  bit m_prev[N];
  bit m_intr, m_to, m_arb;
  int m_id, m_last, m_age, m_gap;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_ovr[i] = 0; m_prev[i] = 0;
    end
    m_intr = 0; m_to = 0; m_arb = 0;
    m_id = 0; m_last = N - 1; m_age = 0; m_gap = 0;
  endtask

  task automatic model_step();
    int g;
    bit any;
    bit rise;
    g = -1; any = 0; m_to = 0;
    for (int i = 0; i < N; i++) any |= m_pend[i];
    if (m_intr) begin
      if (INTR_ACK) begin
        m_intr = 0; m_gap = (GAP > 0) ? GAP : 1;
      end else if (m_age == ACK_TO) begin
        m_intr = 0; m_to = 1; m_gap = (GAP > 0) ? GAP : 1;
      end else begin
        m_age++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (m_arb) begin
      m_arb = 0;
      for (int k = 1; k <= N; k++)
        if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
      if (g >= 0) begin
        m_intr = 1; m_id = g; m_last = g; m_age = 0;
      end
    end else if (any) begin
      m_arb = 1;
    end
    for (int i = 0; i < N; i++) begin
      rise = BTN_PULSE[i] && !m_prev[i];
      if (rise && m_pend[i] && i != g) m_ovr[i] = 1;
      else if (CLR_OVR) m_ovr[i] = 0;
      if (rise) m_pend[i] = 1;
      else if (i == g) m_pend[i] = 0;
      m_prev[i] = BTN_PULSE[i];
    end
  endtask

  task automatic compare_model();
    logic [3:0] ep, eo;
    for (int i = 0; i < N; i++) begin
      ep[i] = m_pend[i]; eo[i] = m_ovr[i];
    end
    checks++;
    if (INTR !== m_intr || INTR_ID !== 2'(m_id) || PENDING !== ep ||
        OVERRUN !== eo || TIMEOUT !== m_to) begin
      failures++;
      $display("FAIL model t=%0t intr/id/pend/ovr/to got %b/%0d/%b/%b/%b required %b/%0d/%b/%b/%b",
               $time, INTR, INTR_ID, PENDING, OVERRUN, TIMEOUT, m_intr, m_id, ep, eo, m_to);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    if (RST) model_reset(); else model_step();
    #1;
    compare_model();
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic wait_intr(output int n);
    n = 0;
    while (INTR !== 1'b1 && n < 600) begin
      cyc();
      n++;
    end
    chk("wait_intr", 32'(INTR), 32'd1);
  endtask

  task automatic do_reset();
    RST = 1'b1; BTN_PULSE = '0; INTR_ACK = 1'b0; CLR_OVR = 1'b0;
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  typedef struct {
    logic [3:0] btn;
    logic       ack;
    logic       clr;
    logic       intr;
    logic [1:0] id;
    logic [3:0] pend;
    logic [3:0] ovr;
    logic       to;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t row(logic [3:0] b, logic a, logic i, logic [1:0] id, logic [3:0] p);
    vec_t v;
    v.btn = b; v.ack = a; v.clr = 1'b0;
    v.intr = i; v.id = id; v.pend = p; v.ovr = 4'b0000; v.to = 1'b0;
    return v;
  endfunction

  initial begin
    int n;
    int cnt;
    logic [3:0] b;
    checks = 0; failures = 0;
    RST = 1'b1; BTN_PULSE = '0; INTR_ACK = 1'b0; CLR_OVR = 1'b0;
    model_reset();

    // Single press on bit 2, ack in cycle 5, then a press on bit 0 with acks outside ASSERT ignored.
    tbl[0]  = row(4'b0100, 1'b0, 1'b0, 2'd0, 4'b0100);
    tbl[1]  = row(4'b0000, 1'b0, 1'b0, 2'd0, 4'b0100);
    tbl[2]  = row(4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000);
    tbl[3]  = row(4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000);
    tbl[4]  = row(4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000);
    tbl[5]  = row(4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000);
    tbl[6]  = row(4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000);
    tbl[7]  = row(4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000);
    tbl[8]  = row(4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000);
    tbl[9]  = row(4'b0001, 1'b0, 1'b0, 2'd2, 4'b0001);
    tbl[10] = row(4'b0000, 1'b1, 1'b0, 2'd2, 4'b0001);
    tbl[11] = row(4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000);
    tbl[12] = row(4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000);
    tbl[13] = row(4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);

    do_reset();
    chk("reset_outputs", 32'({INTR, INTR_ID, PENDING, OVERRUN, TIMEOUT}), 32'd0);

    for (int r = 0; r < 14; r++) begin
      BTN_PULSE = tbl[r].btn; INTR_ACK = tbl[r].ack; CLR_OVR = tbl[r].clr;
      cyc();
      chk($sformatf("tbl_row%0d", r), 32'({INTR, INTR_ID, PENDING, OVERRUN, TIMEOUT}),
          32'({tbl[r].intr, tbl[r].id, tbl[r].pend, tbl[r].ovr, tbl[r].to}));
    end
    INTR_ACK = 1'b0;

    // Simultaneous presses 0,1,3: round-robin order with a low gap between interrupts.
    do_reset();
    BTN_PULSE = 4'b1011; cyc(); BTN_PULSE = '0;
    for (int k = 0; k < 3; k++) begin
      wait_intr(n);
      chk($sformatf("simul_id%0d", k), 32'(INTR_ID), (k == 2) ? 32'd3 : 32'(k));
      if (k > 0) chk($sformatf("simul_gap%0d", k), 32'(n >= GAP), 32'd1);
      INTR_ACK = 1'b1; cyc(); INTR_ACK = 1'b0;
    end

    // Fairness: re-press the granted bit each time; grants must alternate 0,1,0,1.
    do_reset();
    BTN_PULSE = 4'b0011; cyc(); BTN_PULSE = '0;
    for (int k = 0; k < 4; k++) begin
      wait_intr(n);
      chk($sformatf("fair_id%0d", k), 32'(INTR_ID), 32'(k % 2));
      b = '0; b[INTR_ID] = 1'b1;
      BTN_PULSE = b; INTR_ACK = 1'b1; cyc();
      BTN_PULSE = '0; INTR_ACK = 1'b0;
    end
    chk("fair_no_overrun", 32'(OVERRUN), 32'd0);

    // Overrun: two presses on bit 1 while bit 0 is being serviced.
    do_reset();
    BTN_PULSE = 4'b0001; cyc(); BTN_PULSE = '0;
    wait_intr(n);
    BTN_PULSE = 4'b0010; cyc(); BTN_PULSE = '0; cyc();
    BTN_PULSE = 4'b0010; cyc(); BTN_PULSE = '0; cyc();
    chk("ovr_flag", 32'(OVERRUN), 32'h2);
    chk("ovr_pend", 32'(PENDING), 32'h2);
    INTR_ACK = 1'b1; cyc(); INTR_ACK = 1'b0;
    wait_intr(n);
    chk("ovr_grant_id", 32'(INTR_ID), 32'd1);
    INTR_ACK = 1'b1; cyc(); INTR_ACK = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (INTR) cnt++;
    end
    chk("ovr_served_once", 32'(cnt), 32'd0);
    chk("ovr_sticky", 32'(OVERRUN), 32'h2);
    CLR_OVR = 1'b1; cyc(); CLR_OVR = 1'b0;
    chk("ovr_cleared", 32'(OVERRUN), 32'd0);

    // Timeout on bit 3 with no ack, then ack on the final assert cycle suppresses it.
    do_reset();
    BTN_PULSE = 4'b1000; cyc(); BTN_PULSE = '0;
    wait_intr(n);
    chk("to_id", 32'(INTR_ID), 32'd3);
    n = 0;
    while (TIMEOUT !== 1'b1 && n < 300) begin
      cyc();
      n++;
    end
    chk("to_latency", 32'(n), 32'd256);
    chk("to_intr_low", 32'(INTR), 32'd0);
    cyc();
    chk("to_single_pulse", 32'(TIMEOUT), 32'd0);
    BTN_PULSE = 4'b1000; cyc(); BTN_PULSE = '0;
    wait_intr(n);
    repeat (255) cyc();
    INTR_ACK = 1'b1; cyc(); INTR_ACK = 1'b0;
    chk("to_ack_wins_to", 32'(TIMEOUT), 32'd0);
    chk("to_ack_wins_intr", 32'(INTR), 32'd0);
    cyc();
    chk("to_ack_wins_later", 32'(TIMEOUT), 32'd0);

    // Asynchronous reset while INTR is asserted and another press is pending.
    do_reset();
    BTN_PULSE = 4'b0001; cyc(); BTN_PULSE = '0;
    wait_intr(n);
    BTN_PULSE = 4'b0100; cyc(); BTN_PULSE = '0; cyc();
    chk("rst_pre_pend", 32'(PENDING), 32'h4);
    #2;
    RST = 1'b1;
    #1;
    chk("rst_async_intr", 32'(INTR), 32'd0);
    chk("rst_async_pend", 32'(PENDING), 32'd0);
    chk("rst_async_id", 32'(INTR_ID), 32'd0);
    cyc();
    RST = 1'b0;
    BTN_PULSE = 4'b0010; cyc(); BTN_PULSE = '0;
    wait_intr(n);
    chk("rst_next_id", 32'(INTR_ID), 32'd1);
    INTR_ACK = 1'b1; cyc(); INTR_ACK = 1'b0;

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      b = BTN_PULSE;
      for (int i = 0; i < N; i++)
        b[i] = b[i] ? ($urandom_range(1, 0) == 1) : ($urandom_range(11, 0) == 0);
      BTN_PULSE = b;
      INTR_ACK  = INTR ? ($urandom_range(3, 0) == 0) : ($urandom_range(7, 0) == 0);
      CLR_OVR   = ($urandom_range(31, 0) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
